// File: rtl/nx_stream_combiner_pkg.sv
// Shared node-fabric types: message payload, routing direction and arbitration schemes.
package nx_stream_combiner_pkg;

  typedef enum logic [1:0] {
    NORTH = 2'd0,
    EAST  = 2'd1,
    SOUTH = 2'd2,
    WEST  = 2'd3
  } direction_t;

  typedef struct packed {
    logic [3:0] src_node;
    logic [3:0] opcode;
    logic [7:0] payload;
  } node_message_t;

  typedef enum logic [1:0] {
    ARB_ROUND_ROBIN = 2'd0,
    ARB_PREFER_A    = 2'd1,
    ARB_PREFER_B    = 2'd2,
    ARB_INVALID     = 2'd3
  } arb_scheme_e;

endpackage

// File: rtl/nx_stream_combiner.sv
// Two-into-one message stream combiner with a single registered output slot and
// selectable fixed-priority or round-robin arbitration.
module nx_stream_combiner
  import nx_stream_combiner_pkg::*;
#(
  parameter string ARB_SCHEME = "round_robin"
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  node_message_t stream_a_data_i,
  input  direction_t    stream_a_dir_i,
  input  logic          stream_a_valid_i,
  output logic          stream_a_ready_o,
  input  node_message_t stream_b_data_i,
  input  direction_t    stream_b_dir_i,
  input  logic          stream_b_valid_i,
  output logic          stream_b_ready_o,
  output node_message_t comb_data_o,
  output direction_t    comb_dir_o,
  output logic          comb_valid_o,
  input  logic          comb_ready_i
);

  localparam arb_scheme_e SCHEME =
    (ARB_SCHEME == "round_robin") ? ARB_ROUND_ROBIN :
    (ARB_SCHEME == "prefer_a")    ? ARB_PREFER_A    :
    (ARB_SCHEME == "prefer_b")    ? ARB_PREFER_B    : ARB_INVALID;

  if (SCHEME == ARB_INVALID) begin : g_bad_scheme
    $fatal(1, "nx_stream_combiner: unsupported ARB_SCHEME");
  end

  node_message_t comb_data_q, comb_data_d;
  direction_t    comb_dir_q,  comb_dir_d;
  logic          comb_valid_q, comb_valid_d;
  logic          last_b_q, last_b_d;

  logic space_c;
  logic grant_a_c, grant_b_c;
  logic accept_a_c, accept_b_c;

  // Grants depend only on the valids and registered state, never on the readys.
  always_comb begin
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    unique case ({stream_a_valid_i, stream_b_valid_i})
      2'b10: grant_a_c = 1'b1;
      2'b01: grant_b_c = 1'b1;
      2'b11: begin
        case (SCHEME)
          ARB_PREFER_A: grant_a_c = 1'b1;
          ARB_PREFER_B: grant_b_c = 1'b1;
          default: begin
            if (last_b_q) grant_a_c = 1'b1;
            else          grant_b_c = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign space_c          = !comb_valid_q | comb_ready_i;
  assign stream_a_ready_o = space_c & grant_a_c;
  assign stream_b_ready_o = space_c & grant_b_c;
  assign accept_a_c       = stream_a_valid_i & stream_a_ready_o;
  assign accept_b_c       = stream_b_valid_i & stream_b_ready_o;

  // Output slot load; data/dir hold when the slot empties without a new accept.
  always_comb begin
    comb_data_d  = comb_data_q;
    comb_dir_d   = comb_dir_q;
    comb_valid_d = comb_valid_q;
    last_b_d     = last_b_q;
    if (space_c) begin
      comb_valid_d = accept_a_c | accept_b_c;
      if (accept_a_c) begin
        comb_data_d = stream_a_data_i;
        comb_dir_d  = stream_a_dir_i;
        last_b_d    = 1'b0;
      end else if (accept_b_c) begin
        comb_data_d = stream_b_data_i;
        comb_dir_d  = stream_b_dir_i;
        last_b_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      comb_data_q  <= node_message_t'('0);
      comb_dir_q   <= direction_t'('0);
      comb_valid_q <= 1'b0;
      last_b_q     <= 1'b1;
    end else begin
      comb_data_q  <= comb_data_d;
      comb_dir_q   <= comb_dir_d;
      comb_valid_q <= comb_valid_d;
      last_b_q     <= last_b_d;
    end
  end

  assign comb_data_o  = comb_data_q;
  assign comb_dir_o   = comb_dir_q;
  assign comb_valid_o = comb_valid_q;

endmodule

// File: tb/tb_nx_stream_combiner.sv
// Scoreboard bench for nx_stream_combiner: one instance per arbitration scheme, exercised in turn.
module tb_nx_stream_combiner;
  import nx_stream_combiner_pkg::*;

  localparam int unsigned N_DUT = 3;
  localparam int unsigned MSG_W = $bits(node_message_t);

  typedef struct packed {
    node_message_t data;
    direction_t    dir;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  node_message_t a_data  [N_DUT];
  direction_t    a_dir   [N_DUT];
  logic          a_valid [N_DUT];
  logic          a_ready [N_DUT];
  node_message_t b_data  [N_DUT];
  direction_t    b_dir   [N_DUT];
  logic          b_valid [N_DUT];
  logic          b_ready [N_DUT];
  node_message_t c_data  [N_DUT];
  direction_t    c_dir   [N_DUT];
  logic          c_valid [N_DUT];
  logic          c_ready [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam string SCHEME = (g == 0) ? "round_robin" : (g == 1) ? "prefer_a" : "prefer_b";
    nx_stream_combiner #(.ARB_SCHEME(SCHEME)) u_dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .stream_a_data_i  (a_data[g]),
      .stream_a_dir_i   (a_dir[g]),
      .stream_a_valid_i (a_valid[g]),
      .stream_a_ready_o (a_ready[g]),
      .stream_b_data_i  (b_data[g]),
      .stream_b_dir_i   (b_dir[g]),
      .stream_b_valid_i (b_valid[g]),
      .stream_b_ready_o (b_ready[g]),
      .comb_data_o      (c_data[g]),
      .comb_dir_o       (c_dir[g]),
      .comb_valid_o     (c_valid[g]),
      .comb_ready_i     (c_ready[g])
    );
  end

  int    sel;
  logic  dn_ready;
  beat_t src_a[$];
  beat_t src_b[$];
  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fails  = 0;
  int    n_out;
  logic  s_ar, s_br, s_cv;
  node_message_t s_cd;
  direction_t    s_cdir;

  function automatic beat_t mk(input logic [MSG_W-1:0] d, input direction_t dr);
    beat_t b;
    b.data = node_message_t'(d);
    b.dir  = dr;
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s dut=%0d got=%0h exp=%0h", tag, sel, got, exp);
    end
  endtask

  // Present the head of each source queue to the selected instance only.
  task automatic drive();
    for (int i = 0; i < N_DUT; i++) begin
      a_valid[i] = 1'b0; a_data[i] = node_message_t'('0); a_dir[i] = NORTH;
      b_valid[i] = 1'b0; b_data[i] = node_message_t'('0); b_dir[i] = NORTH;
      c_ready[i] = (i == sel) ? dn_ready : 1'b1;
    end
    if (src_a.size() > 0) begin
      a_valid[sel] = 1'b1; a_data[sel] = src_a[0].data; a_dir[sel] = src_a[0].dir;
    end
    if (src_b.size() > 0) begin
      b_valid[sel] = 1'b1; b_data[sel] = src_b[0].data; b_dir[sel] = src_b[0].dir;
    end
  endtask

  // One clock: sample at negedge, score any output transfer, retire accepted inputs.
  task automatic tick();
    logic  acc_a, acc_b;
    beat_t e;
    @(negedge clk);
    s_ar = a_ready[sel]; s_br = b_ready[sel]; s_cv = c_valid[sel];
    s_cd = c_data[sel];  s_cdir = c_dir[sel];
    acc_a = a_valid[sel] & a_ready[sel];
    acc_b = b_valid[sel] & b_ready[sel];
    if (c_valid[sel] && c_ready[sel] && !rst) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("out_unexpected", 32'(c_data[sel]), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(c_data[sel]), 32'(e.data));
        check("out_dir", 32'(c_dir[sel]), 32'(e.dir));
      end
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      if (acc_a) void'(src_a.pop_front());
      if (acc_b) void'(src_b.pop_front());
    end
    drive();
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() > 0; k++) tick();
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_a.delete(); src_b.delete(); exp_q.delete();
    dn_ready = 1'b1;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
  endtask

  initial begin
    logic want_a;
    rst = 1'b1; dn_ready = 1'b1; sel = 0; n_out = 0;
    drive();
    for (int s = 0; s < N_DUT; s++) begin
      sel = s;
      do_reset();
      check("rst_valid", 32'(c_valid[sel]), 32'd0);
      check("rst_data", 32'(c_data[sel]), 32'd0);
      check("rst_dir", 32'(c_dir[sel]), 32'd0);

      // A only valid
      src_a.push_back(mk(16'h1234, NORTH));
      exp_q.push_back(mk(16'h1234, NORTH));
      drive();
      tick();
      check("aonly_a_ready", 32'(s_ar), 32'd1);
      check("aonly_b_ready", 32'(s_br), 32'd0);
      tick();
      check("aonly_valid", 32'(s_cv), 32'd1);
      tick();
      check("idle_valid_drop", 32'(s_cv), 32'd0);

      // Continuous contention, four messages per side
      do_reset();
      for (int i = 0; i < 4; i++) begin
        src_a.push_back(mk(16'hA000 + 16'(i), direction_t'(2'(i))));
        src_b.push_back(mk(16'hB000 + 16'(i), direction_t'(2'(3 - i))));
      end
      if (s == 0) begin
        for (int i = 0; i < 4; i++) begin
          exp_q.push_back(mk(16'hA000 + 16'(i), direction_t'(2'(i))));
          exp_q.push_back(mk(16'hB000 + 16'(i), direction_t'(2'(3 - i))));
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          for (int i = 0; i < 4; i++) begin
            if ((s == 1) == (p == 0)) exp_q.push_back(mk(16'hA000 + 16'(i), direction_t'(2'(i))));
            else                      exp_q.push_back(mk(16'hB000 + 16'(i), direction_t'(2'(3 - i))));
          end
        end
      end
      drive();
      n_out = 0;
      for (int k = 0; k < 9; k++) begin
        tick();
        if (k < 4) begin
          want_a = (s == 0) ? (k % 2 == 0) : (s == 1);
          check("cont_a_ready", 32'(s_ar), 32'(want_a));
          check("cont_b_ready", 32'(s_br), 32'(!want_a));
        end
      end
      check("cont_throughput", 32'(n_out), 32'd8);
      check("cont_exp_left", 32'(exp_q.size()), 32'd0);

      // Backpressure on a held message with a waiting competitor
      src_a.push_back(mk(16'hC001, EAST));
      src_b.push_back(mk(16'hC002, SOUTH));
      if (s == 2) begin
        exp_q.push_back(mk(16'hC002, SOUTH));
        exp_q.push_back(mk(16'hC001, EAST));
      end else begin
        exp_q.push_back(mk(16'hC001, EAST));
        exp_q.push_back(mk(16'hC002, SOUTH));
      end
      drive();
      tick();
      dn_ready = 1'b0;
      drive();
      for (int k = 0; k < 3; k++) begin
        tick();
        check("bp_valid", 32'(s_cv), 32'd1);
        check("bp_data", 32'(s_cd), 32'(exp_q[0].data));
        check("bp_dir", 32'(s_cdir), 32'(exp_q[0].dir));
        check("bp_a_ready", 32'(s_ar), 32'd0);
        check("bp_b_ready", 32'(s_br), 32'd0);
      end
      dn_ready = 1'b1;
      drive();
      drain(10);

      // Reset while the slot holds a message
      dn_ready = 1'b0;
      src_a.push_back(mk(16'hD00D, WEST));
      drive();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive();
      check("rstmid_valid", 32'(c_valid[sel]), 32'd0);
      check("rstmid_data", 32'(c_data[sel]), 32'd0);
      check("rstmid_dir", 32'(c_dir[sel]), 32'd0);

      // First contention after reset
      dn_ready = 1'b1;
      src_a.push_back(mk(16'hE001, NORTH));
      src_b.push_back(mk(16'hE002, EAST));
      want_a = (s != 2);
      if (want_a) begin
        exp_q.push_back(mk(16'hE001, NORTH));
        exp_q.push_back(mk(16'hE002, EAST));
      end else begin
        exp_q.push_back(mk(16'hE002, EAST));
        exp_q.push_back(mk(16'hE001, NORTH));
      end
      drive();
      tick();
      check("post_rst_a_ready", 32'(s_ar), 32'(want_a));
      check("post_rst_b_ready", 32'(s_br), 32'(!want_a));
      drain(10);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog dut=%0d simulation time limit reached", sel);
    $fatal(1, "time limit");
  end

endmodule
